// File: rtl/lut_neuron_array.sv
// ============================================================================
// Module      : lut_neuron_array
// Description : N independent runtime-loadable truth-table neurons behind a
//               two-stage valid/ready lookup pipeline with full backpressure.
//               Optional per-entry even parity: define LUT_NEURON_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_neuron_array #(
    parameter int N_NEURONS = 4,
    parameter int IN_BITS   = 8,
    parameter int OUT_BITS  = 1,
    parameter int NB_W      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS*OUT_BITS-1:0] out_data,
`ifdef LUT_NEURON_PARITY_EN
    output logic [N_NEURONS-1:0]          out_perr,
`endif
    input  logic                          cfg_we,
    input  logic [NB_W-1:0]               cfg_neuron,
    input  logic [IN_BITS-1:0]            cfg_addr,
    input  logic [OUT_BITS-1:0]           cfg_wdata,
    output logic                          init_done
);

    localparam int c_DEPTH = 1 << IN_BITS;
`ifdef LUT_NEURON_PARITY_EN
    localparam int c_ENT_W = OUT_BITS + 1;
`else
    localparam int c_ENT_W = OUT_BITS;
`endif
    localparam logic [IN_BITS-1:0] c_LAST_ADDR = {IN_BITS{1'b1}};

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [IN_BITS-1:0]              r_init_cnt;
    logic                            w_stall;
    logic                            w_in_ready;
    logic                            w_accept;
    logic                            w_cfg_hit;
    logic [c_ENT_W-1:0]              w_wr_entry;
    logic                            r_s1_valid;
    logic [N_NEURONS*IN_BITS-1:0]    r_s1_data;
    logic [N_NEURONS*OUT_BITS-1:0]   w_lut_data;
    logic                            r_out_valid;
    logic [N_NEURONS*OUT_BITS-1:0]   r_out_data;
`ifdef LUT_NEURON_PARITY_EN
    logic [N_NEURONS-1:0]            w_lut_perr;
    logic [N_NEURONS-1:0]            r_out_perr;
`endif

    // ------------------------------------------------------------------
    // Control FSM: clear every table once, then serve lookups forever
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_INIT:  if (r_init_cnt == c_LAST_ADDR) w_state_next = S_RUN;
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_cnt <= '0;
        end else if (r_state == S_INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
        end
    end

    assign w_stall    = r_out_valid & ~out_ready;
    assign w_in_ready = (r_state == S_RUN) & ~w_stall;
    assign w_accept   = in_valid & w_in_ready;
    assign w_cfg_hit  = cfg_we & (r_state == S_RUN);

`ifdef LUT_NEURON_PARITY_EN
    assign w_wr_entry = {^cfg_wdata, cfg_wdata};
`else
    assign w_wr_entry = cfg_wdata;
`endif

    // ------------------------------------------------------------------
    // Per-neuron tables; an out-of-range cfg_neuron matches no instance
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N_NEURONS; g++) begin : g_neuron
        logic [c_ENT_W-1:0] r_table [c_DEPTH];
        logic [c_ENT_W-1:0] w_rd_entry;
        logic               w_wr_sel;

        assign w_wr_sel = w_cfg_hit && (cfg_neuron == NB_W'(g));

        always_ff @(posedge clk) begin
            if (r_state == S_INIT) begin
                r_table[r_init_cnt] <= '0;
            end else if (w_wr_sel) begin
                r_table[cfg_addr] <= w_wr_entry;
            end
        end

        assign w_rd_entry = r_table[r_s1_data[g*IN_BITS +: IN_BITS]];
        assign w_lut_data[g*OUT_BITS +: OUT_BITS] = w_rd_entry[OUT_BITS-1:0];
`ifdef LUT_NEURON_PARITY_EN
        assign w_lut_perr[g] = ^w_rd_entry;
`endif
    end

    // ------------------------------------------------------------------
    // Pipeline: stage 1 holds addresses, stage 2 holds lookup results
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
`ifdef LUT_NEURON_PARITY_EN
            r_out_perr  <= '0;
`endif
        end else if (!w_stall) begin
            r_out_valid <= r_s1_valid;
            r_out_data  <= w_lut_data;
`ifdef LUT_NEURON_PARITY_EN
            r_out_perr  <= w_lut_perr;
`endif
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign init_done = (r_state == S_RUN);
`ifdef LUT_NEURON_PARITY_EN
    assign out_perr  = r_out_perr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lut_neuron_array.sv
// ============================================================================
// Module      : tb_lut_neuron_array
// Description : Self-checking bench for lut_neuron_array against a table model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lut_neuron_array;

    localparam int c_N  = 4;
    localparam int c_IB = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
`ifdef LUT_NEURON_PARITY_EN
    logic [3:0]  out_perr;
`endif
    logic        cfg_we;
    logic [1:0]  cfg_neuron;
    logic [7:0]  cfg_addr;
    logic [0:0]  cfg_wdata;
    logic        init_done;

    lut_neuron_array #(
        .N_NEURONS (c_N),
        .IN_BITS   (c_IB),
        .OUT_BITS  (1)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef LUT_NEURON_PARITY_EN
        .out_perr   (out_perr),
`endif
        .cfg_we     (cfg_we),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_bad   = 0;
    bit         ref_tab [c_N][256];
    logic [3:0] exp_q [$];
    int         n_recv  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model(input logic [31:0] d);
        logic [3:0] r;
        for (int i = 0; i < c_N; i++) r[i] = ref_tab[i][d[i*8 +: 8]];
        return r;
    endfunction

    task automatic clear_ref();
        for (int n = 0; n < c_N; n++)
            for (int a = 0; a < 256; a++) ref_tab[n][a] = 1'b0;
    endtask

    task automatic cfg_write(input int n, input int a, input bit d);
        cfg_we = 1'b1; cfg_neuron = 2'(n); cfg_addr = 8'(a); cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        ref_tab[n][a] = d;
    endtask

    // Waits for init_done while watching that nothing leaks out during INIT.
    task automatic wait_init(output int cycles, output bit saw_ready, output bit saw_valid);
        cycles = 0; saw_ready = 1'b0; saw_valid = 1'b0;
        while (!init_done && cycles < 2000) begin
            if (in_ready)  saw_ready = 1'b1;
            if (out_valid) saw_valid = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic single_beat(input string tag, input logic [31:0] d, input logic [3:0] exp);
        in_valid = 1'b1; in_data = d; out_ready = 1'b1; #1;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(exp));
        @(posedge clk); #1;
    endtask

    // One cycle of streaming: record handshakes that happen at the coming edge.
    task automatic drive_cycle(input bit v, input logic [31:0] d, input bit rdy, output bit acc);
        bit         hold;
        logic [3:0] held;
        logic [3:0] e;
        in_valid = v; in_data = d; out_ready = rdy; #1;
        if (out_valid && out_ready) begin
            n_recv++;
            if (exp_q.size() == 0) begin
                chk("stream_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("stream_data", 32'(out_data), 32'(e));
            end
        end
        acc = v && in_ready;
        if (acc) exp_q.push_back(model(d));
        hold = out_valid && !out_ready;
        held = out_data;
        @(posedge clk); #1;
        if (hold) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(held));
        end
    endtask

    initial begin
        int         cyc;
        int         sent;
        bit         s_rdy;
        bit         s_val;
        bit         acc;
        logic [3:0] exp_old;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_wdata = '0;
        clear_ref();
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        wait_init(cyc, s_rdy, s_val);
        chk("init_len", 32'(cyc), 32'd256);
        chk("init_no_ready", 32'(s_rdy), 32'd0);
        chk("run_in_ready", 32'(in_ready), 32'd1);
        single_beat("cleared", 32'hFFFF_FFFF, 4'b0000);

        cfg_write(1, 8'h2A, 1'b1);
        cfg_write(0, 8'h2A, 1'b0);
        single_beat("load", 32'h0000_2A2A, 4'b0010);

        // Random tables, then a 300-beat stream under random backpressure
        for (int n = 0; n < c_N; n++)
            for (int a = 0; a < 256; a++) cfg_write(n, a, 1'($urandom));
        sent = 0; cyc = 0; n_recv = 0;
        while ((sent < 300 || exp_q.size() != 0) && cyc < 5000) begin
            drive_cycle((sent < 300) && ($urandom_range(0, 3) != 0), $urandom,
                        1'($urandom_range(0, 1)), acc);
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_recv", 32'(n_recv), 32'd300);
        chk("stream_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Write to an entry on the same edge its lookup is registered
        cfg_write(0, 8'h05, 1'b0);
        exp_old = model(32'h0505_0505);
        in_valid = 1'b1; in_data = 32'h0505_0505; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_neuron = 2'd0; cfg_addr = 8'h05; cfg_wdata = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        ref_tab[0][8'h05] = 1'b1;
        chk("coll_valid", 32'(out_valid), 32'd1);
        chk("coll_old", 32'(out_data), 32'(exp_old));
        @(posedge clk); #1;
        single_beat("coll_new", 32'h0505_0505, model(32'h0505_0505));

        // Reset with two beats in flight
        in_valid = 1'b1; in_data = 32'h0101_0101; out_ready = 1'b1;
        @(posedge clk); #1;
        in_data = 32'h0202_0202;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_drop", 32'(out_valid), 32'd0);
        chk("rst_ready_low", 32'(in_ready), 32'd0);
        cfg_we = 1'b1; cfg_neuron = 2'd3; cfg_addr = 8'h77; cfg_wdata = 1'b1;
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        wait_init(cyc, s_rdy, s_val);
        cfg_we = 1'b0;
        clear_ref();
        exp_q.delete();
        chk("reinit_len", 32'(cyc), 32'd256);
        chk("reinit_no_ready", 32'(s_rdy), 32'd0);
        chk("reinit_no_valid", 32'(s_val), 32'd0);
        s_val = 1'b0;
        repeat (4) begin
            if (out_valid) s_val = 1'b1;
            @(posedge clk); #1;
        end
        chk("no_stale", 32'(s_val), 32'd0);
        single_beat("recleared", 32'h7700_0005, 4'b0000);

`ifdef LUT_NEURON_PARITY_EN
        cfg_write(2, 8'h33, 1'b1);
        u_dut.g_neuron[2].r_table[8'h33] = u_dut.g_neuron[2].r_table[8'h33] ^ 2'b01;
        in_valid = 1'b1; in_data = 32'h3333_3333; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("perr_valid", 32'(out_valid), 32'd1);
        chk("perr_data", 32'(out_data), 32'(model(32'h3333_3333) ^ 4'b0100));
        chk("perr_flag", 32'(out_perr), 32'h4);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h3434_3434;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("perr_clean", 32'(out_perr), 32'h0);
        @(posedge clk); #1;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
